// File: rtl/spdif_pkg.sv
// Shared types, slot layout and parity helper for the S/PDIF subframe decoder.
package spdif_pkg;

  typedef enum logic [1:0] {
    S   = 2'd0,
    M   = 2'd1,
    L   = 2'd2,
    ERR = 2'd3
  } pulse_t;

  typedef enum logic [1:0] {
    PRE_B = 2'd0,
    PRE_M = 2'd1,
    PRE_W = 2'd2
  } pre_t;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam int DATA_SLOTS = 28;
  localparam int AUX_LSB    = 0;
  localparam int AUDIO_MSB  = 23;
  localparam int V_IDX      = 24;
  localparam int U_IDX      = 25;
  localparam int C_IDX      = 26;
  localparam int P_IDX      = 27;

  // Even parity over the whole data field (parity slot included) holds when XOR is 0.
  function automatic logic even_parity_ok(input logic [DATA_SLOTS-1:0] bits);
    return ~(^bits);
  endfunction

endpackage

// File: rtl/bmc_pulse_classifier.sv
// Synchronises the raw line, finds its edges and classifies each pulse width
// as a 1, 2 or 3 UI pulse, or as an error. A gap with no edge longer than
// T_LONG_MAX produces a single timeout ERR pulse.
module bmc_pulse_classifier
  import spdif_pkg::*;
#(
  parameter int T_SHORT_MAX = 14,
  parameter int T_MIN       = 5,
  parameter int T_MED_MAX   = 24,
  parameter int T_LONG_MAX  = 34
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   din,
  output logic   pulse_valid,
  output pulse_t pulse_type
);

  localparam int            CW      = $clog2(T_LONG_MAX + 3);
  localparam logic [CW-1:0] CNT_SAT = CW'(T_LONG_MAX + 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          prev_r;
  logic [CW-1:0] cnt_r;
  logic          edge_s;
  logic          timeout_s;
  logic [CW-1:0] width_s;

  assign edge_s    = sync2_r ^ prev_r;
  assign width_s   = cnt_r + CW'(1);
  assign timeout_s = !edge_s && (cnt_r == CW'(T_LONG_MAX));

  // Two-flop synchroniser plus the delayed copy used for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Cycles since the last edge, saturating one past the longest legal pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (edge_s) begin
      cnt_r <= '0;
    end else if (cnt_r < CNT_SAT) begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Width classification at each edge; the timeout is reported as ERR.
  always_comb begin
    pulse_valid = edge_s | timeout_s;
    pulse_type  = ERR;
    if (!edge_s) begin
      pulse_type = ERR;
    end else if (width_s < CW'(T_MIN)) begin
      pulse_type = ERR;
    end else if (width_s <= CW'(T_SHORT_MAX)) begin
      pulse_type = S;
    end else if (width_s <= CW'(T_MED_MAX)) begin
      pulse_type = M;
    end else if (width_s <= CW'(T_LONG_MAX)) begin
      pulse_type = L;
    end else begin
      pulse_type = ERR;
    end
  end

endmodule

// File: rtl/spdif_subframe_decoder.sv
// Decodes S/PDIF subframes from classified biphase-mark pulses: preamble
// detection, 28-slot data decode, channel-order and parity checks, lock
// tracking and the registered parallel sample output.
module spdif_subframe_decoder
  import spdif_pkg::*;
#(
  parameter int T_SHORT_MAX = 14,
  parameter int T_MIN       = 5,
  parameter int T_MED_MAX   = 24,
  parameter int T_LONG_MAX  = 34,
  parameter int AUDIO_W     = 24,
  parameter int LOCK_COUNT  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din,
  output logic [AUDIO_W-1:0] sample_out,
  output logic               ch_out,
  output logic               block_start,
  output logic [2:0]         vuc_out,
  output logic               valid_out,
  output logic               parity_err,
  output logic               lock
);

  localparam int         GW        = $clog2(LOCK_COUNT + 1);
  localparam logic [4:0] LAST_SLOT = 5'(DATA_SLOTS - 1);

  logic   pulse_valid_s;
  pulse_t pulse_type_s;

  bmc_pulse_classifier #(
    .T_SHORT_MAX (T_SHORT_MAX),
    .T_MIN       (T_MIN),
    .T_MED_MAX   (T_MED_MAX),
    .T_LONG_MAX  (T_LONG_MAX)
  ) u_classifier (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .pulse_valid (pulse_valid_s),
    .pulse_type  (pulse_type_s)
  );

  state_t                state_r;
  state_t                state_s;
  logic                  need_lead_r;
  logic [1:0]            pre_idx_r;
  pulse_t                pre0_r;
  pulse_t                pre1_r;
  logic                  first_r;
  logic                  last_w_r;
  pre_t                  cur_pre_r;
  logic                  half_r;
  logic [4:0]            bit_cnt_r;
  logic [DATA_SLOTS-1:0] data_r;
  logic [GW-1:0]         good_cnt_r;

  logic                  err_s;
  logic                  hunt_lead_s;
  logic                  lead_ok_s;
  logic                  pre_pulse_s;
  logic                  pre_done_s;
  logic                  pre_match_s;
  pre_t                  pre_type_s;
  logic                  half_set_s;
  logic                  bit_v_s;
  logic                  bit_s;
  logic                  complete_s;
  logic [DATA_SLOTS-1:0] data_full_s;
  logic                  parity_ok_s;
  logic [GW-1:0]         good_next_s;
  logic                  lock_next_s;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= HUNT;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and per-pulse decode strobes.
  always_comb begin
    state_s     = state_r;
    err_s       = 1'b0;
    hunt_lead_s = 1'b0;
    lead_ok_s   = 1'b0;
    pre_pulse_s = 1'b0;
    pre_done_s  = 1'b0;
    half_set_s  = 1'b0;
    bit_v_s     = 1'b0;
    bit_s       = 1'b0;
    complete_s  = 1'b0;
    pre_match_s = 1'b0;
    pre_type_s  = PRE_B;

    // The three pulses following the leading L identify the preamble.
    if (pre0_r == S && pre1_r == S && pulse_type_s == L) begin
      pre_match_s = 1'b1;
      pre_type_s  = PRE_B;
    end else if (pre0_r == L && pre1_r == S && pulse_type_s == S) begin
      pre_match_s = 1'b1;
      pre_type_s  = PRE_M;
    end else if (pre0_r == M && pre1_r == S && pulse_type_s == M) begin
      pre_match_s = 1'b1;
      pre_type_s  = PRE_W;
    end else begin
      pre_match_s = 1'b0;
      pre_type_s  = PRE_B;
    end

    case (state_r)
      HUNT: begin
        if (pulse_valid_s && pulse_type_s == L) begin
          hunt_lead_s = 1'b1;
          state_s     = PRE;
        end else begin
          state_s = HUNT;
        end
      end
      PRE: begin
        if (!pulse_valid_s) begin
          state_s = PRE;
        end else if (pulse_type_s == ERR) begin
          err_s   = 1'b1;
          state_s = HUNT;
        end else if (need_lead_r) begin
          if (pulse_type_s == L) begin
            lead_ok_s = 1'b1;
          end else begin
            err_s   = 1'b1;
            state_s = HUNT;
          end
        end else if (pre_idx_r != 2'd2) begin
          pre_pulse_s = 1'b1;
        end else if (!pre_match_s) begin
          err_s   = 1'b1;
          state_s = HUNT;
        end else if (!first_r && ((pre_type_s == PRE_W) == last_w_r)) begin
          // Left must follow right and vice versa once the stream is tracked.
          err_s   = 1'b1;
          state_s = HUNT;
        end else begin
          pre_done_s = 1'b1;
          state_s    = DATA;
        end
      end
      DATA: begin
        if (!pulse_valid_s) begin
          state_s = DATA;
        end else if (!half_r) begin
          if (pulse_type_s == M) begin
            bit_v_s = 1'b1;
            bit_s   = 1'b0;
          end else if (pulse_type_s == S) begin
            half_set_s = 1'b1;
          end else begin
            err_s   = 1'b1;
            state_s = HUNT;
          end
        end else begin
          if (pulse_type_s == S) begin
            bit_v_s = 1'b1;
            bit_s   = 1'b1;
          end else begin
            err_s   = 1'b1;
            state_s = HUNT;
          end
        end
        if (bit_v_s && bit_cnt_r == LAST_SLOT) begin
          complete_s = 1'b1;
          state_s    = PRE;
        end else begin
          complete_s = 1'b0;
        end
      end
      default: begin
        state_s = HUNT;
      end
    endcase
  end

  // Completed-word view, parity result and lock update for the output stage.
  always_comb begin
    data_full_s = {bit_s, data_r[DATA_SLOTS-1:1]};
    parity_ok_s = even_parity_ok(data_full_s);
    if (good_cnt_r == GW'(LOCK_COUNT)) begin
      good_next_s = good_cnt_r;
    end else begin
      good_next_s = good_cnt_r + GW'(1);
    end
    lock_next_s = lock | (good_next_s == GW'(LOCK_COUNT));
  end

  // Preamble collection and data-slot shift register (LSB arrives first).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      need_lead_r <= 1'b0;
      pre_idx_r   <= 2'd0;
      pre0_r      <= S;
      pre1_r      <= S;
      first_r     <= 1'b0;
      last_w_r    <= 1'b0;
      cur_pre_r   <= PRE_B;
      half_r      <= 1'b0;
      bit_cnt_r   <= 5'd0;
      data_r      <= '0;
    end else begin
      if (hunt_lead_s) begin
        need_lead_r <= 1'b0;
        pre_idx_r   <= 2'd0;
        first_r     <= 1'b1;
      end
      if (lead_ok_s) begin
        need_lead_r <= 1'b0;
        pre_idx_r   <= 2'd0;
      end
      if (pre_pulse_s) begin
        if (pre_idx_r == 2'd0) begin
          pre0_r <= pulse_type_s;
        end else begin
          pre1_r <= pulse_type_s;
        end
        pre_idx_r <= pre_idx_r + 2'd1;
      end
      if (pre_done_s) begin
        first_r   <= 1'b0;
        last_w_r  <= (pre_type_s == PRE_W);
        cur_pre_r <= pre_type_s;
        half_r    <= 1'b0;
        bit_cnt_r <= 5'd0;
      end
      if (half_set_s) begin
        half_r <= 1'b1;
      end
      if (bit_v_s) begin
        data_r    <= data_full_s;
        half_r    <= 1'b0;
        bit_cnt_r <= bit_cnt_r + 5'd1;
      end
      if (complete_s) begin
        need_lead_r <= 1'b1;
      end
    end
  end

  // Lock tracking and registered sample/status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      good_cnt_r  <= '0;
      lock        <= 1'b0;
      valid_out   <= 1'b0;
      parity_err  <= 1'b0;
      sample_out  <= '0;
      ch_out      <= 1'b0;
      block_start <= 1'b0;
      vuc_out     <= 3'd0;
    end else begin
      valid_out  <= 1'b0;
      parity_err <= 1'b0;
      if (err_s) begin
        good_cnt_r <= '0;
        lock       <= 1'b0;
      end else if (complete_s && parity_ok_s) begin
        good_cnt_r <= good_next_s;
        lock       <= lock_next_s;
        if (lock_next_s) begin
          valid_out   <= 1'b1;
          sample_out  <= data_full_s[AUDIO_MSB -: AUDIO_W];
          ch_out      <= (cur_pre_r == PRE_W);
          block_start <= (cur_pre_r == PRE_B);
          vuc_out     <= {data_full_s[V_IDX], data_full_s[U_IDX], data_full_s[C_IDX]};
        end
      end else if (complete_s) begin
        parity_err <= 1'b1;
        good_cnt_r <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spdif_subframe_decoder.sv
// Scoreboard bench: an ideal 10 clk/UI biphase-mark stream drives a 24-bit
// and a 16-bit decoder; expected samples are queued as subframes are sent
// and popped when valid_out fires.
module tb_spdif_subframe_decoder;

  localparam int KB = 0;
  localparam int KM = 1;
  localparam int KW = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        din;

  logic [23:0] sample_out;
  logic        ch_out, block_start, valid_out, parity_err, lock;
  logic [2:0]  vuc_out;
  logic [15:0] sample16;
  logic        ch16, bs16, valid16, perr16, lock16;
  logic [2:0]  vuc16;

  typedef struct {
    logic [23:0] sample;
    logic        ch;
    logic        bs;
    logic [2:0]  vuc;
  } want_t;

  want_t       want_q[$];
  logic [15:0] want16_q[$];
  want_t       mon_w;
  logic [15:0] mon_w16;

  int n_cmp     = 0;
  int n_bad     = 0;
  int valid_cnt = 0;
  int perr_cnt  = 0;

  always #5 clk = ~clk;

  spdif_subframe_decoder #(.AUDIO_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .din(din),
    .sample_out(sample_out), .ch_out(ch_out), .block_start(block_start),
    .vuc_out(vuc_out), .valid_out(valid_out), .parity_err(parity_err), .lock(lock)
  );

  spdif_subframe_decoder #(.AUDIO_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .din(din),
    .sample_out(sample16), .ch_out(ch16), .block_start(bs16),
    .vuc_out(vuc16), .valid_out(valid16), .parity_err(perr16), .lock(lock16)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // One biphase-mark pulse: toggle the line, hold it for w clock cycles.
  task automatic pulse(input int w);
    din = ~din;
    repeat (w) @(negedge clk);
  endtask

  // Sends one subframe (or its first nbits slots). glitch selects a '1' slot
  // sent as two 4-cycle pulses; -1 for none.
  task automatic send_sf(input int kind, input logic [23:0] word, input logic [2:0] vuc,
                         input bit bad_par, input bit exp_valid, input int nbits, input int glitch);
    logic [27:0] d;
    want_t       w;
    d[23:0] = word;
    d[24]   = vuc[2];
    d[25]   = vuc[1];
    d[26]   = vuc[0];
    d[27]   = (^d[26:0]) ^ bad_par;
    if (exp_valid) begin
      w.sample = word;
      w.ch     = (kind == KW);
      w.bs     = (kind == KB);
      w.vuc    = vuc;
      want_q.push_back(w);
      want16_q.push_back(word[23:8]);
    end
    pulse(30);
    case (kind)
      KB:      begin pulse(10); pulse(10); pulse(30); end
      KM:      begin pulse(30); pulse(10); pulse(10); end
      default: begin pulse(20); pulse(10); pulse(20); end
    endcase
    for (int i = 0; i < nbits; i++) begin
      if (i == glitch) begin
        pulse(4);
        pulse(4);
      end else if (d[i]) begin
        pulse(10);
        pulse(10);
      end else begin
        pulse(20);
      end
    end
  endtask

  task automatic good_sf(input int kind, input logic [23:0] word, input logic [2:0] vuc, input bit exp_valid);
    send_sf(kind, word, vuc, 1'b0, exp_valid, 28, -1);
  endtask

  // Output monitor: pops the scoreboard on every valid_out of either decoder.
  always @(negedge clk) begin
    if (valid_out) begin
      valid_cnt++;
      if (want_q.size() == 0) begin
        check_eq("unexp_valid", 32'(valid_out), 32'd0);
      end else begin
        mon_w = want_q.pop_front();
        check_eq("sample", 32'(sample_out), 32'(mon_w.sample));
        check_eq("ch", 32'(ch_out), 32'(mon_w.ch));
        check_eq("block_start", 32'(block_start), 32'(mon_w.bs));
        check_eq("vuc", 32'(vuc_out), 32'(mon_w.vuc));
      end
    end
    if (valid16) begin
      if (want16_q.size() == 0) begin
        check_eq("unexp_valid16", 32'(valid16), 32'd0);
      end else begin
        mon_w16 = want16_q.pop_front();
        check_eq("sample16", 32'(sample16), 32'(mon_w16));
      end
    end
    if (parity_err) begin
      perr_cnt++;
    end
  end

  initial begin
    rst_n = 1'b0;
    din   = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_sample", 32'(sample_out), 32'd0);
    check_eq("rst_lock", 32'(lock), 32'd0);
    check_eq("rst_valid", 32'(valid_out), 32'd0);
    check_eq("rst_ch", 32'(ch_out), 32'd0);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);

    // Acquisition: the fourth good subframe sets lock and is output.
    good_sf(KB, 24'h111111, 3'b000, 1'b0);
    good_sf(KW, 24'h222222, 3'b100, 1'b0);
    good_sf(KM, 24'h333333, 3'b000, 1'b0);
    check_eq("lock_after2", 32'(lock), 32'd0);
    good_sf(KW, 24'h123456, 3'b010, 1'b1);
    check_eq("lock_after3", 32'(lock), 32'd0);
    good_sf(KB, 24'hABCDE0, 3'b001, 1'b1);
    check_eq("lock_after4", 32'(lock), 32'd1);
    check_eq("valid_once", 32'(valid_cnt), 32'd1);

    // Parity error while locked.
    good_sf(KW, 24'h654321, 3'b111, 1'b1);
    send_sf(KM, 24'h0F0F0F, 3'b000, 1'b1, 1'b0, 28, -1);
    good_sf(KW, 24'h0A0B0C, 3'b101, 1'b1);
    check_eq("perr_count", 32'(perr_cnt), 32'd1);
    check_eq("lock_after_perr", 32'(lock), 32'd1);
    good_sf(KM, 24'h112233, 3'b000, 1'b1);

    // Line stuck mid-data: timeout drops lock; reacquire.
    good_sf(KW, 24'h445566, 3'b000, 1'b1);
    send_sf(KM, 24'h777777, 3'b000, 1'b0, 1'b0, 10, -1);
    repeat (40) @(negedge clk);
    check_eq("lock_timeout", 32'(lock), 32'd0);
    good_sf(KB, 24'h010203, 3'b000, 1'b0);
    good_sf(KW, 24'h040506, 3'b000, 1'b0);
    good_sf(KM, 24'h070809, 3'b000, 1'b0);
    good_sf(KW, 24'h0A0B0D, 3'b010, 1'b1);
    good_sf(KB, 24'hFEDCBA, 3'b100, 1'b1);
    check_eq("lock_reacq", 32'(lock), 32'd1);

    // Two W preambles in a row.
    good_sf(KW, 24'h13579B, 3'b011, 1'b1);
    good_sf(KW, 24'h2468AC, 3'b000, 1'b0);
    check_eq("lock_ww", 32'(lock), 32'd0);
    good_sf(KB, 24'h300001, 3'b000, 1'b0);
    good_sf(KW, 24'h300002, 3'b000, 1'b0);
    good_sf(KM, 24'h300003, 3'b000, 1'b0);
    good_sf(KW, 24'h300004, 3'b001, 1'b1);
    good_sf(KB, 24'h300005, 3'b000, 1'b1);

    // Sub-T_MIN pulses inside a data slot.
    good_sf(KW, 24'h400001, 3'b000, 1'b1);
    send_sf(KM, 24'h5A5A5A, 3'b000, 1'b0, 1'b0, 28, 6);
    good_sf(KW, 24'h400002, 3'b000, 1'b0);
    check_eq("lock_glitch", 32'(lock), 32'd0);
    good_sf(KB, 24'h400003, 3'b000, 1'b0);
    good_sf(KW, 24'h400004, 3'b000, 1'b0);
    good_sf(KM, 24'h400005, 3'b110, 1'b1);
    good_sf(KW, 24'h400006, 3'b000, 1'b1);

    // Reset in the middle of a subframe.
    send_sf(KM, 24'h500001, 3'b000, 1'b0, 1'b0, 12, -1);
    check_eq("lock_prerst", 32'(lock), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mrst_sample", 32'(sample_out), 32'd0);
    check_eq("mrst_ch", 32'(ch_out), 32'd0);
    check_eq("mrst_bs", 32'(block_start), 32'd0);
    check_eq("mrst_vuc", 32'(vuc_out), 32'd0);
    check_eq("mrst_valid", 32'(valid_out), 32'd0);
    check_eq("mrst_perr", 32'(parity_err), 32'd0);
    check_eq("mrst_lock", 32'(lock), 32'd0);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);

    good_sf(KB, 24'h600001, 3'b000, 1'b0);
    good_sf(KW, 24'h600002, 3'b000, 1'b0);
    good_sf(KM, 24'h600003, 3'b000, 1'b0);
    good_sf(KW, 24'h123456, 3'b111, 1'b1);
    pulse(30);
    repeat (100) @(negedge clk);

    check_eq("queue_drained", 32'(want_q.size()), 32'd0);
    check_eq("queue16_drained", 32'(want16_q.size()), 32'd0);
    check_eq("perr_total", 32'(perr_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
